// File: rtl/riscv_mem_wb_pkg.sv
// Shared encodings for the memory-response / writeback stage: writeback source codes,
// load funct3 sizes, FSM states and the load alignment rule.
package riscv_mem_wb_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

    // Unknown funct3 codes behave as LW, so they need a word-aligned address.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return addr[0];
            default:       return addr != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mem_wb_load_align.sv
// Picks the byte/half lane of a word-aligned load response and sign/zero-extends it by funct3.
module riscv_mem_wb_load_align
    import riscv_mem_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = rdata_i[{addr_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/riscv_mem_wb.sv
// Memory-response / writeback stage: registers EX results, waits for load data, extends it and
// drives the register-file write port, with forwarding and stall information back upstream.
module riscv_mem_wb
    import riscv_mem_wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [4:0]      ex_wb_rd,
    input  logic            ex_wb_reg_write,
    input  logic [1:0]      ex_wb_sel,
    input  logic            ex_is_load,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_rvalid,
    output logic            mem_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_load_pending,
    output logic [4:0]      fwd_load_rd,
    output logic            load_err,
    output logic            misalign_err,
    output wb_state_e       dbg_state
);

    localparam int            CW       = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    wb_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_addr_q, ld_addr_d;
    logic            pend_we_q, pend_we_d;
    logic [4:0]      pend_addr_q, pend_addr_d;
    logic [XLEN-1:0] pend_data_q, pend_data_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            load_err_q, load_err_d;
    logic            misalign_q, misalign_d;

    logic            accept, load_done, load_abort, ex_misaligned, load_start, direct_we;
    logic [XLEN-1:0] direct_data, ld_data;

    // Handshake: EX presents a result with ex_valid and must hold it unchanged while mem_stall is
    // high; the result is taken on every rising edge where ex_valid=1 and mem_stall=0.
    assign mem_stall     = (state_q == ST_LOAD_WAIT) && !dmem_rvalid;
    assign accept        = ex_valid && !mem_stall;
    assign load_done     = (state_q == ST_LOAD_WAIT) && dmem_rvalid;
    assign load_abort    = (state_q == ST_LOAD_WAIT) && !dmem_rvalid && (cnt_q == CNT_LAST);
    assign ex_misaligned = load_misaligned(ex_funct3, ex_alu_result[1:0]);
    assign load_start    = accept && ex_is_load && !ex_misaligned && ex_wb_reg_write &&
                           (ex_wb_sel == WB_MEM) && (ex_wb_rd != 5'd0);
    assign direct_we     = accept && !ex_is_load && ex_wb_reg_write && (ex_wb_rd != 5'd0);
    assign direct_data   = (ex_wb_sel == WB_PC4) ? ex_pc + XLEN'(4) : ex_alu_result;

    riscv_mem_wb_load_align #(.XLEN(XLEN)) u_align (
        .rdata_i  (dmem_rdata),
        .addr_i   (ld_addr_q),
        .funct3_i (ld_f3_q),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ld_rd_q     <= '0;
            ld_f3_q     <= '0;
            ld_addr_q   <= '0;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            load_err_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_rd_q     <= ld_rd_d;
            ld_f3_q     <= ld_f3_d;
            ld_addr_q   <= ld_addr_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            load_err_q  <= load_err_d;
            misalign_q  <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (load_start) state_d = ST_LOAD_WAIT;
            ST_LOAD_WAIT: begin
                if (load_done)       state_d = load_start ? ST_LOAD_WAIT : ST_IDLE;
                else if (load_abort) state_d = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        ld_rd_d     = ld_rd_q;
        ld_f3_d     = ld_f3_q;
        ld_addr_d   = ld_addr_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        load_err_d  = load_err_q | load_abort;
        misalign_d  = accept && ex_is_load && ex_misaligned;

        if (state_q == ST_LOAD_WAIT)
            cnt_d = (load_done || load_abort) ? '0 : cnt_q + CW'(1);

        if (load_start) begin
            cnt_d     = '0;
            ld_rd_d   = ex_wb_rd;
            ld_f3_d   = ex_funct3;
            ld_addr_d = ex_alu_result[1:0];
        end else if (state_d == ST_IDLE) begin
            ld_rd_d   = '0;
            ld_f3_d   = '0;
            ld_addr_d = '0;
        end

        // One write per edge: an older held result or a completing load wins the port, and a
        // non-load accepted on that edge waits one cycle in the pending register.
        if (pend_we_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pend_addr_q;
            rf_wdata_d = pend_data_q;
            pend_we_d  = 1'b0;
        end else if (load_done) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = ld_data;
        end

        if (direct_we) begin
            if (pend_we_q || load_done) begin
                pend_we_d   = 1'b1;
                pend_addr_d = ex_wb_rd;
                pend_data_d = direct_data;
            end else begin
                rf_we_d    = 1'b1;
                rf_waddr_d = ex_wb_rd;
                rf_wdata_d = direct_data;
            end
        end
    end

    assign rf_we            = rf_we_q;
    assign rf_waddr         = rf_waddr_q;
    assign rf_wdata         = rf_wdata_q;
    assign fwd_load_pending = (state_q == ST_LOAD_WAIT);
    assign fwd_load_rd      = ld_rd_q;
    assign load_err         = load_err_q;
    assign misalign_err     = misalign_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_riscv_mem_wb.sv
// Directed and randomized checks of riscv_mem_wb against a cycle-level reference model that keeps
// expected register-file writes in an ordered queue, one retired per clock edge.
`timescale 1ns/1ps
module tb_riscv_mem_wb;
    import riscv_mem_wb_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ex_valid = 1'b0;
    logic [XLEN-1:0] ex_alu_result = '0;
    logic [XLEN-1:0] ex_pc = '0;
    logic [4:0]      ex_wb_rd = '0;
    logic            ex_wb_reg_write = 1'b0;
    logic [1:0]      ex_wb_sel = '0;
    logic            ex_is_load = 1'b0;
    logic [2:0]      ex_funct3 = '0;
    logic [XLEN-1:0] dmem_rdata = '0;
    logic            dmem_rvalid = 1'b0;
    logic            mem_stall, rf_we, fwd_load_pending, load_err, misalign_err;
    logic [4:0]      rf_waddr, fwd_load_rd;
    logic [XLEN-1:0] rf_wdata;
    wb_state_e       dbg_state;

    always #5 clk = ~clk;

    riscv_mem_wb #(.XLEN(XLEN), .LOAD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_pc(ex_pc), .ex_wb_rd(ex_wb_rd), .ex_wb_reg_write(ex_wb_reg_write),
        .ex_wb_sel(ex_wb_sel), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
        .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .mem_stall(mem_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_load_pending(fwd_load_pending), .fwd_load_rd(fwd_load_rd),
        .load_err(load_err), .misalign_err(misalign_err), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding load, its age in stalled cycles, and ordered writes.
    logic            m_wait = 1'b0;
    int              m_waited = 0;
    logic [4:0]      m_rd = '0;
    logic [2:0]      m_f3 = '0;
    logic [1:0]      m_addr = '0;
    logic            m_lerr = 1'b0;
    logic            m_mis = 1'b0;
    logic [36:0]     exp_q[$];

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        return a != 0;
    endfunction

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] pc,
                          input logic [4:0] rd, input logic we, input logic [1:0] sel,
                          input logic ld, input logic [2:0] f3);
        ex_valid = v; ex_alu_result = alu; ex_pc = pc; ex_wb_rd = rd;
        ex_wb_reg_write = we; ex_wb_sel = sel; ex_is_load = ld; ex_funct3 = f3;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_waited = 0; m_rd = '0; m_lerr = 1'b0; m_mis = 1'b0;
        exp_q.delete();
    endtask

    // One clock: check combinational outputs, advance the model over the edge, check registered ones.
    task automatic cycle();
        logic stall, acc;
        logic [36:0] e;
        #1;
        stall = m_wait && !dmem_rvalid;
        check("mem_stall", mem_stall, stall);
        check("fwd_pending", fwd_load_pending, m_wait);
        check("fwd_rd", fwd_load_rd, m_wait ? m_rd : 5'd0);
        acc = ex_valid && !stall;
        m_mis = 1'b0;
        if (m_wait) begin
            if (dmem_rvalid) begin
                exp_q.push_back({m_rd, load_value(dmem_rdata, m_addr, m_f3)});
                m_wait = 1'b0;
                m_rd = '0;
            end else begin
                m_waited++;
                if (m_waited == TMO) begin
                    m_lerr = 1'b1;
                    m_wait = 1'b0;
                    m_rd = '0;
                end
            end
        end
        if (acc) begin
            if (ex_is_load) begin
                if (is_misaligned(ex_funct3, ex_alu_result[1:0])) m_mis = 1'b1;
                else if (ex_wb_sel == 2'd1 && ex_wb_reg_write && ex_wb_rd != 0) begin
                    m_wait = 1'b1; m_waited = 0; m_rd = ex_wb_rd;
                    m_f3 = ex_funct3; m_addr = ex_alu_result[1:0];
                end
            end else if (ex_wb_reg_write && ex_wb_rd != 0) begin
                exp_q.push_back({ex_wb_rd, (ex_wb_sel == 2'd2) ? ex_pc + 32'd4 : ex_alu_result});
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_we", rf_we, 1'b1);
            check("rf_waddr", rf_waddr, e[36:32]);
            check("rf_wdata", rf_wdata, e[31:0]);
        end else begin
            check("rf_we_idle", rf_we, 1'b0);
        end
        check("misalign_err", misalign_err, m_mis);
        check("load_err", load_err, m_lerr);
    endtask

    initial begin
        #12;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 5'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_lerr", load_err, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU result
        set_ex(1'b1, 32'd30, 32'h0, 5'd1, 1'b1, 2'd0, 1'b0, 3'd0);
        cycle();
        check("alu_wdata", rf_wdata, 32'd30);
        // JAL link, then rd=0 variant
        set_ex(1'b1, 32'h0, 32'h100, 5'd1, 1'b1, 2'd2, 1'b0, 3'd0);
        cycle();
        check("jal_wdata", rf_wdata, 32'h104);
        set_ex(1'b1, 32'h0, 32'h100, 5'd0, 1'b1, 2'd2, 1'b0, 3'd0);
        cycle();
        check("jal_rd0_we", rf_we, 1'b0);

        // LB / LBU on lane 1 with three stall cycles before data
        for (int k = 0; k < 2; k++) begin
            set_ex(1'b1, 32'h0D, 32'h0, 5'd5, 1'b1, 2'd1, 1'b1, (k == 0) ? 3'b000 : 3'b100);
            cycle();
            idle_ex();
            for (int s = 0; s < 3; s++) cycle();
            dmem_rdata = 32'h0000_8000; dmem_rvalid = 1'b1;
            cycle();
            dmem_rvalid = 1'b0;
            check("lb_lbu_wdata", rf_wdata, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
        end

        // LH upper half, then misaligned LW
        set_ex(1'b1, 32'h06, 32'h0, 5'd6, 1'b1, 2'd1, 1'b1, 3'b001);
        cycle();
        idle_ex();
        dmem_rdata = 32'hF00D_0000; dmem_rvalid = 1'b1;
        cycle();
        dmem_rvalid = 1'b0;
        check("lh_wdata", rf_wdata, 32'hFFFF_F00D);
        set_ex(1'b1, 32'h12, 32'h0, 5'd7, 1'b1, 2'd1, 1'b1, 3'b010);
        cycle();
        idle_ex();
        check("lw_misalign", misalign_err, 1'b1);
        cycle();

        // Timeout, then a late response that must be ignored
        set_ex(1'b1, 32'h20, 32'h0, 5'd8, 1'b1, 2'd1, 1'b1, 3'b010);
        cycle();
        idle_ex();
        for (int s = 0; s < TMO; s++) cycle();
        check("timeout_lerr", load_err, 1'b1);
        dmem_rdata = 32'hDEAD_BEEF; dmem_rvalid = 1'b1;
        cycle();
        dmem_rvalid = 1'b0;
        cycle();

        // Load response and a new ADD accepted on the same edge
        set_ex(1'b1, 32'h40, 32'h0, 5'd9, 1'b1, 2'd1, 1'b1, 3'b010);
        cycle();
        set_ex(1'b1, 32'd7, 32'h0, 5'd3, 1'b1, 2'd0, 1'b0, 3'd0);
        dmem_rdata = 32'h1234_5678; dmem_rvalid = 1'b1;
        cycle();
        idle_ex();
        dmem_rvalid = 1'b0;
        check("b2b_load_rd", rf_waddr, 5'd9);
        cycle();
        check("b2b_add_rd", rf_waddr, 5'd3);
        check("b2b_add_data", rf_wdata, 32'd7);

        // Reset while a load is outstanding
        set_ex(1'b1, 32'h44, 32'h0, 5'd10, 1'b1, 2'd1, 1'b1, 3'b010);
        cycle();
        idle_ex();
        cycle();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_mid_pending", fwd_load_pending, 1'b0);
        check("rst_mid_lerr", load_err, 1'b0);
        check("rst_mid_we", rf_we, 1'b0);
        rst_n = 1'b1;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic ld;
            logic [1:0] sel;
            ld  = ($urandom_range(0, 9) < 4);
            sel = 2'($urandom_range(0, 3));
            if (ld && $urandom_range(0, 4) != 0) sel = 2'd1;
            set_ex($urandom_range(0, 9) < 6, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 19) != 0, sel, ld, 3'($urandom_range(0, 7)));
            dmem_rdata  = $urandom;
            dmem_rvalid = ($urandom_range(0, 9) < 3);
            cycle();
        end
        idle_ex();
        dmem_rvalid = 1'b1;
        cycle();
        dmem_rvalid = 1'b0;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
